// File: rtl/mode_hub_pkg.sv
// Shared types and helpers for the mode controller: FSM encoding, blank digit
// code and a one-hot builder sized for the widest supported board.
package mode_hub_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    BLANK = 1'b1
  } state_t;

  localparam int MAX_MODES = 8;
  localparam int BLANK_DIG = 0;

  function automatic logic [MAX_MODES-1:0] onehot(input int idx, input int n);
    logic [MAX_MODES-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_MODES; i++) begin
      if (i == idx && i < n) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mode_hub_if.sv
// Mode-change request handshake between the mode selector and the hub.
interface mode_hub_if #(
  parameter int MODE_W = 3
);
  logic              req_valid;
  logic [MODE_W-1:0] req_mode;
  logic              req_ready;
  logic              req_err;

  modport master (output req_valid, req_mode, input req_ready, req_err);
  modport slave  (input req_valid, req_mode, output req_ready, req_err);
endinterface

// File: rtl/mode_mux.sv
// Registered N_MODES:1 mux of digit bus, buzzer and twinkle with forced blanking.
module mode_mux
  import mode_hub_pkg::*;
#(
  parameter int N_MODES = 5,
  parameter int MODE_W  = 3,
  parameter int N_DIG   = 6,
  parameter int DIG_W   = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [MODE_W-1:0]          sel,
  input  logic                       blank,
  input  logic [N_MODES*N_DIG*DIG_W-1:0] seg_in,
  input  logic [N_MODES-1:0]         beep_in,
  input  logic [N_MODES-1:0]         twinkle_in,
  output logic [N_DIG*DIG_W-1:0]     seg_out,
  output logic                       beep_out,
  output logic                       twinkle_out
);

  localparam int SEG_W = N_DIG * DIG_W;

  logic [SEG_W-1:0] seg_p0;
  logic             beep_p0;
  logic             twinkle_p0;

  always_comb begin
    seg_p0     = '0;
    beep_p0    = 1'b0;
    twinkle_p0 = 1'b0;
    for (int k = 0; k < N_MODES; k++) begin
      if (sel == MODE_W'(k)) begin
        seg_p0     = seg_in[k*SEG_W +: SEG_W];
        beep_p0    = beep_in[k];
        twinkle_p0 = twinkle_in[k];
      end
    end
  end

  // p0 -> output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out     <= '0;
      beep_out    <= 1'b0;
      twinkle_out <= 1'b0;
    end else if (blank) begin
      seg_out     <= {N_DIG{DIG_W'(BLANK_DIG)}};
      beep_out    <= 1'b0;
      twinkle_out <= 1'b0;
    end else begin
      seg_out     <= seg_p0;
      beep_out    <= beep_p0;
      twinkle_out <= twinkle_p0;
    end
  end

endmodule

// File: rtl/mode_hub.sv
// Mode controller: tracks the active mode, hands out enables/resets, and blanks
// the shared display and buzzer for BLANK_CYC cycles on every mode change.
module mode_hub
  import mode_hub_pkg::*;
#(
  parameter int N_MODES   = 5,
  parameter int MODE_W    = 3,
  parameter int N_DIG     = 6,
  parameter int DIG_W     = 6,
  parameter int HOME      = 0,
  parameter int BLANK_CYC = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           sw_en,
  mode_hub_if.slave                      req,
  input  logic [N_MODES-1:0]             ret_req,
  input  logic [N_MODES*N_DIG*DIG_W-1:0] seg_in,
  input  logic [N_MODES-1:0]             beep_in,
  input  logic [N_MODES-1:0]             twinkle_in,
  output logic [N_MODES-1:0]             mode_en,
  output logic [N_MODES-1:0]             mode_rst_n,
  output logic [MODE_W-1:0]              cur_mode,
  output logic [N_MODES-1:0]             led_mode,
  output logic                           busy,
  output logic [N_DIG*DIG_W-1:0]         seg_out,
  output logic                           beep_out,
  output logic                           twinkle_out
);

  localparam int CNT_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(BLANK_CYC - 1);
  localparam logic [MODE_W-1:0]  HOME_M    = MODE_W'(HOME);
  localparam logic [N_MODES-1:0] HOME_OH   = N_MODES'(onehot(HOME, N_MODES));
  localparam logic [MODE_W:0]    N_MODES_X = (MODE_W+1)'(N_MODES);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [MODE_W-1:0]  target;
  logic               req_err_q;
  logic [N_MODES-1:0] cur_oh;
  logic [N_MODES-1:0] tgt_oh;
  logic               ret_hit;
  logic               req_oor;
  logic               req_switch;
  logic               go;
  logic               blank;

  assign cur_oh = N_MODES'(onehot(int'(cur_mode), N_MODES));
  assign tgt_oh = N_MODES'(onehot(int'(target), N_MODES));

  // Return from the active mode outranks any selector request in the same cycle
  assign ret_hit    = (|(ret_req & cur_oh)) && (cur_mode != HOME_M);
  assign req_oor    = {1'b0, req.req_mode} >= N_MODES_X;
  assign req_switch = req.req_valid && !req_oor && (req.req_mode != cur_mode);
  assign go         = (state == RUN) && (ret_hit || req_switch);

  assign busy          = (state == BLANK);
  assign req.req_ready = !busy;
  assign req.req_err   = req_err_q;
  assign led_mode      = cur_oh;

  // Blank starts on the accepting edge so the old mode's data never leaks into BLANK
  assign blank = !sw_en || (state == BLANK) || go;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      cnt        <= '0;
      cur_mode   <= HOME_M;
      target     <= HOME_M;
      mode_en    <= HOME_OH;
      mode_rst_n <= HOME_OH;
      req_err_q  <= 1'b0;
    end else if (!sw_en) begin
      state      <= RUN;
      cnt        <= '0;
      cur_mode   <= HOME_M;
      target     <= HOME_M;
      mode_en    <= '0;
      mode_rst_n <= '0;
      req_err_q  <= 1'b0;
    end else begin
      req_err_q <= 1'b0;
      unique case (state)
        RUN: begin
          if (ret_hit) begin
            target     <= HOME_M;
            state      <= BLANK;
            cnt        <= CNT_LOAD;
            mode_en    <= '0;
            mode_rst_n <= '0;
          end else if (req_switch) begin
            target     <= req.req_mode;
            state      <= BLANK;
            cnt        <= CNT_LOAD;
            mode_en    <= '0;
            mode_rst_n <= '0;
          end else begin
            req_err_q  <= req.req_valid && req_oor;
            mode_en    <= cur_oh;
            mode_rst_n <= cur_oh;
          end
        end
        BLANK: begin
          if (cnt == '0) begin
            state      <= RUN;
            cur_mode   <= target;
            mode_en    <= tgt_oh;
            mode_rst_n <= tgt_oh;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
      endcase
    end
  end

  mode_mux #(
    .N_MODES (N_MODES),
    .MODE_W  (MODE_W),
    .N_DIG   (N_DIG),
    .DIG_W   (DIG_W)
  ) u_mux (
    .clk         (clk),
    .rst_n       (rst_n),
    .sel         (cur_mode),
    .blank       (blank),
    .seg_in      (seg_in),
    .beep_in     (beep_in),
    .twinkle_in  (twinkle_in),
    .seg_out     (seg_out),
    .beep_out    (beep_out),
    .twinkle_out (twinkle_out)
  );

endmodule

// File: tb/tb_mode_hub.sv
// Directed bench for mode_hub: reset, switching, returns, errors, sw_en and async reset aborts.
module tb_mode_hub;

  localparam int N_MODES = 5;
  localparam int MODE_W  = 3;
  localparam int N_DIG   = 6;
  localparam int DIG_W   = 6;
  localparam int SEG_W   = N_DIG * DIG_W;

  logic                       clk;
  logic                       rst_n;
  logic                       sw_en;
  logic [N_MODES-1:0]         ret_req;
  logic [N_MODES*SEG_W-1:0]   seg_in;
  logic [N_MODES-1:0]         beep_in;
  logic [N_MODES-1:0]         twinkle_in;
  logic [N_MODES-1:0]         mode_en;
  logic [N_MODES-1:0]         mode_rst_n;
  logic [MODE_W-1:0]          cur_mode;
  logic [N_MODES-1:0]         led_mode;
  logic                       busy;
  logic [SEG_W-1:0]           seg_out;
  logic                       beep_out;
  logic                       twinkle_out;

  int total = 0;
  int bad   = 0;

  mode_hub_if #(.MODE_W(MODE_W)) req_if ();

  mode_hub #(
    .N_MODES(N_MODES), .MODE_W(MODE_W), .N_DIG(N_DIG), .DIG_W(DIG_W),
    .HOME(0), .BLANK_CYC(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw_en       (sw_en),
    .req         (req_if),
    .ret_req     (ret_req),
    .seg_in      (seg_in),
    .beep_in     (beep_in),
    .twinkle_in  (twinkle_in),
    .mode_en     (mode_en),
    .mode_rst_n  (mode_rst_n),
    .cur_mode    (cur_mode),
    .led_mode    (led_mode),
    .busy        (busy),
    .seg_out     (seg_out),
    .beep_out    (beep_out),
    .twinkle_out (twinkle_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SEG_W-1:0] slice(input int k);
    return seg_in[k*SEG_W +: SEG_W];
  endfunction

  initial begin
    rst_n = 1'b1;
    sw_en = 1'b1;
    ret_req = '0;
    req_if.req_valid = 1'b0;
    req_if.req_mode  = '0;
    beep_in    = 5'b10100;
    twinkle_in = 5'b01010;
    seg_in     = '0;
    // Home mode shows blank digits; others show distinct codes per digit
    for (int k = 1; k < N_MODES; k++)
      for (int d = 0; d < N_DIG; d++)
        seg_in[(k*N_DIG + d)*DIG_W +: DIG_W] = 6'(k*8 + d);

    #2 rst_n = 1'b0;
    #1;
    chk("rst_cur_mode", 64'(cur_mode), 64'd0);
    chk("rst_mode_en", 64'(mode_en), 64'b00001);
    chk("rst_mode_rst_n", 64'(mode_rst_n), 64'b00001);
    chk("rst_seg_out", 64'(seg_out), 64'd0);
    chk("rst_req_err", 64'(req_if.req_err), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("idle_cur_mode", 64'(cur_mode), 64'd0);
    chk("idle_mode_en", 64'(mode_en), 64'b00001);
    chk("idle_mode_rst_n", 64'(mode_rst_n), 64'b00001);
    chk("idle_seg_out", 64'(seg_out), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_ready", 64'(req_if.req_ready), 64'd1);
    chk("idle_led", 64'(led_mode), 64'b00001);

    // Switch 0 -> 2
    req_if.req_valid = 1'b1; req_if.req_mode = 3'd2;
    tick();
    req_if.req_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("sw2_busy_t%0d", i), 64'(busy), 64'd1);
      chk($sformatf("sw2_en_t%0d", i), 64'(mode_en), 64'd0);
      chk($sformatf("sw2_rstn_t%0d", i), 64'(mode_rst_n), 64'd0);
      chk($sformatf("sw2_seg_t%0d", i), 64'(seg_out), 64'd0);
      chk($sformatf("sw2_ready_t%0d", i), 64'(req_if.req_ready), 64'd0);
      tick();
    end
    chk("sw2_cur_mode", 64'(cur_mode), 64'd2);
    chk("sw2_mode_en", 64'(mode_en), 64'b00100);
    chk("sw2_mode_rst_n", 64'(mode_rst_n), 64'b00100);
    chk("sw2_busy_done", 64'(busy), 64'd0);
    chk("sw2_seg_still_blank", 64'(seg_out), 64'd0);
    tick();
    chk("sw2_seg_out", 64'(seg_out), 64'(slice(2)));
    chk("sw2_seg_digit0", 64'(seg_out[5:0]), 64'd16);
    chk("sw2_beep", 64'(beep_out), 64'd1);
    chk("sw2_twinkle", 64'(twinkle_out), 64'd0);
    chk("sw2_led", 64'(led_mode), 64'b00100);

    // Return request from an inactive mode is ignored
    ret_req = 5'b00010;
    tick();
    ret_req = '0;
    chk("ret_inactive_busy", 64'(busy), 64'd0);
    chk("ret_inactive_mode", 64'(cur_mode), 64'd2);
    // Return from the active mode
    ret_req = 5'b00100;
    tick();
    ret_req = '0;
    chk("ret_busy", 64'(busy), 64'd1);
    repeat (3) tick();
    chk("ret_busy_last", 64'(busy), 64'd1);
    tick();
    chk("ret_cur_mode", 64'(cur_mode), 64'd0);
    chk("ret_mode_en", 64'(mode_en), 64'b00001);
    chk("ret_busy_done", 64'(busy), 64'd0);

    // Back to mode 2, then return and request collide
    req_if.req_valid = 1'b1; req_if.req_mode = 3'd2;
    tick();
    req_if.req_valid = 1'b0;
    repeat (4) tick();
    chk("sw2b_cur_mode", 64'(cur_mode), 64'd2);
    ret_req = 5'b00100;
    req_if.req_valid = 1'b1; req_if.req_mode = 3'd4;
    tick();
    ret_req = '0;
    req_if.req_mode = 3'd3;
    chk("collide_busy", 64'(busy), 64'd1);
    chk("collide_ready", 64'(req_if.req_ready), 64'd0);
    tick();
    req_if.req_valid = 1'b0;
    repeat (3) tick();
    chk("collide_cur_mode", 64'(cur_mode), 64'd0);
    chk("collide_busy_done", 64'(busy), 64'd0);
    tick();
    chk("drop_busy", 64'(busy), 64'd0);
    chk("drop_cur_mode", 64'(cur_mode), 64'd0);

    // Out-of-range request
    req_if.req_valid = 1'b1; req_if.req_mode = 3'd6;
    tick();
    req_if.req_valid = 1'b0;
    chk("oor_err", 64'(req_if.req_err), 64'd1);
    chk("oor_busy", 64'(busy), 64'd0);
    tick();
    chk("oor_err_clear", 64'(req_if.req_err), 64'd0);
    chk("oor_cur_mode", 64'(cur_mode), 64'd0);
    // Request for the current mode
    req_if.req_valid = 1'b1; req_if.req_mode = 3'd0;
    tick();
    req_if.req_valid = 1'b0;
    chk("same_busy", 64'(busy), 64'd0);
    chk("same_err", 64'(req_if.req_err), 64'd0);
    chk("same_mode_en", 64'(mode_en), 64'b00001);

    // sw_en drop mid-BLANK
    req_if.req_valid = 1'b1; req_if.req_mode = 3'd3;
    tick();
    req_if.req_valid = 1'b0;
    tick();
    sw_en = 1'b0;
    tick();
    chk("swen_mode_en", 64'(mode_en), 64'd0);
    chk("swen_mode_rst_n", 64'(mode_rst_n), 64'd0);
    chk("swen_busy", 64'(busy), 64'd0);
    chk("swen_cur_mode", 64'(cur_mode), 64'd0);
    sw_en = 1'b1;
    tick();
    chk("swen_back_mode", 64'(cur_mode), 64'd0);
    chk("swen_back_busy", 64'(busy), 64'd0);
    chk("swen_back_en", 64'(mode_en), 64'b00001);
    chk("swen_back_rstn", 64'(mode_rst_n), 64'b00001);

    // Mode 4 outputs, then async reset mid-BLANK
    req_if.req_valid = 1'b1; req_if.req_mode = 3'd4;
    tick();
    req_if.req_valid = 1'b0;
    repeat (5) tick();
    chk("sw4_cur_mode", 64'(cur_mode), 64'd4);
    chk("sw4_led", 64'(led_mode), 64'b10000);
    chk("sw4_seg_out", 64'(seg_out), 64'(slice(4)));
    chk("sw4_beep", 64'(beep_out), 64'd1);
    chk("sw4_twinkle", 64'(twinkle_out), 64'd0);
    req_if.req_valid = 1'b1; req_if.req_mode = 3'd1;
    tick();
    req_if.req_valid = 1'b0;
    tick();
    chk("pre_arst_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cur_mode", 64'(cur_mode), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_mode_en", 64'(mode_en), 64'b00001);
    chk("arst_mode_rst_n", 64'(mode_rst_n), 64'b00001);
    chk("arst_seg_out", 64'(seg_out), 64'd0);
    rst_n = 1'b1;
    tick(); tick();
    chk("post_arst_mode", 64'(cur_mode), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
